// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline,
// with a data-memory wait FSM, watchdog and saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_regread1,
  input  logic             ID_regread2,
  input  logic             EX_memread,
  input  logic [4:0]       EX_wraddr,
  input  logic             EX_redirect,
  input  logic             MEM_memread,
  input  logic             MEM_memwrite,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             pc_redirect,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_flush,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] MWAIT = 1'b1;

  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             mem_err_q;
  logic             err_sticky_q;

  logic mem_op;
  logic wd_expire;
  logic mem_wait;
  logic hit_rs;
  logic hit_rt;
  logic load_use;
  logic sel_wait;
  logic sel_redir;
  logic sel_lu;

  assign mem_op = MEM_memread | MEM_memwrite;

  assign wd_expire = (state_q == MWAIT) && !dmem_ack &&
                     (wcnt_q >= WC_LAST);

  assign mem_wait = ((state_q == RUN) && mem_op && !dmem_ack) ||
                    ((state_q == MWAIT) && !dmem_ack && !wd_expire);

  assign hit_rs = ID_regread1 && (ID_rs == EX_wraddr);
  assign hit_rt = ID_regread2 && (ID_rt == EX_wraddr);

  assign load_use = EX_memread && (EX_wraddr != 5'd0) &&
                    (hit_rs || hit_rt);

  // Mutually exclusive selects encode the priority wait > redirect > load-use
  assign sel_wait  = rst_n && mem_wait;
  assign sel_redir = rst_n && !mem_wait && EX_redirect;
  assign sel_lu    = rst_n && !mem_wait && !EX_redirect && load_use;

  always_comb begin
    pc_stall     = 1'b0;
    pc_redirect  = 1'b0;
    IF_ID_stall  = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_stall  = 1'b0;
    ID_EX_flush  = 1'b0;
    EX_MEM_stall = 1'b0;
    MEM_WB_flush = 1'b0;
    unique case (1'b1)
      sel_wait: begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_stall  = 1'b1;
        EX_MEM_stall = 1'b1;
        MEM_WB_flush = 1'b1;
      end
      sel_redir: begin
        pc_redirect = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      sel_lu: begin
        pc_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_EX_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dmem_req = rst_n && ((state_q == MWAIT) || mem_op);

  // wcnt counts cycles since the request rose, so the request cycle
  // in RUN is the first waited cycle
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (state_q == RUN) begin
      if (mem_op && !dmem_ack) begin
        state_d = MWAIT;
        wcnt_d  = WC_W'(1);
      end
    end else begin
      if (dmem_ack || wd_expire) begin
        state_d = RUN;
        wcnt_d  = '0;
      end else begin
        wcnt_d = wcnt_q + WC_W'(1);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (pc_redirect && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wcnt_q       <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      mem_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wcnt_q       <= wcnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      mem_err_q    <= wd_expire;
      err_sticky_q <= err_sticky_q | wd_expire;
    end
  end

  assign mem_err    = mem_err_q;
  assign err_sticky = err_sticky_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table plus hand sequences
// for memory wait, watchdog, saturation and async reset.
module tb_pipe_hazard_ctrl;

  localparam logic [8:0] NONE = 9'b000000000;
  localparam logic [8:0] REQ  = 9'b000000001;
  localparam logic [8:0] LU   = 9'b101001000;
  localparam logic [8:0] RED  = 9'b010101000;
  localparam logic [8:0] WAIT = 9'b101010111;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rr1;
    logic       rr2;
    logic       exmr;
    logic [4:0] wa;
    logic       redir;
    logic       mr;
    logic       mw;
    logic       ack;
    logic [8:0] exp;
    string      nm;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_wraddr;
  logic       ID_regread1, ID_regread2, EX_memread, EX_redirect;
  logic       MEM_memread, MEM_memwrite, dmem_ack;

  logic        a_pcs, a_pcr, a_ifs, a_iff, a_ies, a_ief, a_ems, a_mwf;
  logic        a_req, a_err, a_stk;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pcs, b_pcr, b_ifs, b_iff, b_ies, b_ief, b_ems, b_mwf;
  logic        b_req, b_err, b_stk;
  logic [1:0]  b_scnt, b_fcnt;
  logic [8:0]  a_out, b_out;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(16), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_regread1(ID_regread1), .ID_regread2(ID_regread2),
    .EX_memread(EX_memread), .EX_wraddr(EX_wraddr),
    .EX_redirect(EX_redirect),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .dmem_ack(dmem_ack),
    .pc_stall(a_pcs), .pc_redirect(a_pcr),
    .IF_ID_stall(a_ifs), .IF_ID_flush(a_iff),
    .ID_EX_stall(a_ies), .ID_EX_flush(a_ief),
    .EX_MEM_stall(a_ems), .MEM_WB_flush(a_mwf),
    .dmem_req(a_req), .mem_err(a_err), .err_sticky(a_stk),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_regread1(ID_regread1), .ID_regread2(ID_regread2),
    .EX_memread(EX_memread), .EX_wraddr(EX_wraddr),
    .EX_redirect(EX_redirect),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .dmem_ack(dmem_ack),
    .pc_stall(b_pcs), .pc_redirect(b_pcr),
    .IF_ID_stall(b_ifs), .IF_ID_flush(b_iff),
    .ID_EX_stall(b_ies), .ID_EX_flush(b_ief),
    .EX_MEM_stall(b_ems), .MEM_WB_flush(b_mwf),
    .dmem_req(b_req), .mem_err(b_err), .err_sticky(b_stk),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  assign a_out = {a_pcs, a_pcr, a_ifs, a_iff, a_ies,
                  a_ief, a_ems, a_mwf, a_req};
  assign b_out = {b_pcs, b_pcr, b_ifs, b_iff, b_ies,
                  b_ief, b_ems, b_mwf, b_req};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ID_rs = 5'd0; ID_rt = 5'd0;
    ID_regread1 = 1'b0; ID_regread2 = 1'b0;
    EX_memread = 1'b0; EX_wraddr = 5'd0; EX_redirect = 1'b0;
    MEM_memread = 1'b0; MEM_memwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_lu();
    idle();
    ID_rs = 5'd8; ID_regread1 = 1'b1;
    EX_memread = 1'b1; EX_wraddr = 5'd8;
  endtask

  task automatic apply(input vec_t v);
    ID_rs = v.rs; ID_rt = v.rt;
    ID_regread1 = v.rr1; ID_regread2 = v.rr2;
    EX_memread = v.exmr; EX_wraddr = v.wa; EX_redirect = v.redir;
    MEM_memread = v.mr; MEM_memwrite = v.mw; dmem_ack = v.ack;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t tbl[$];
  int   e_stall, e_flush;
  int   n_req, n_ems, n_err, f0;

  initial begin
    tbl.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, NONE, "idle"});
    tbl.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8,
                    1'b0, 1'b0, 1'b0, 1'b1, LU, "lu_rs"});
    tbl.push_back('{5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0,
                    1'b0, 1'b0, 1'b0, 1'b1, NONE, "lu_r0"});
    tbl.push_back('{5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5,
                    1'b0, 1'b0, 1'b0, 1'b0, LU, "lu_rt"});
    tbl.push_back('{5'd1, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5,
                    1'b0, 1'b0, 1'b0, 1'b0, NONE, "lu_rt_noread"});
    tbl.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 5'd8,
                    1'b0, 1'b0, 1'b0, 1'b0, NONE, "no_load"});
    tbl.push_back('{5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8,
                    1'b1, 1'b0, 1'b0, 1'b1, RED, "redir_over_lu"});
    tbl.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                    1'b1, 1'b0, 1'b0, 1'b0, RED, "redir"});
    tbl.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b1, REQ, "load_0wait"});
    tbl.push_back('{5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3,
                    1'b0, 1'b0, 1'b1, 1'b1, LU | REQ, "store_lu"});
    tbl.push_back('{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0,
                    1'b1, 1'b0, 1'b1, 1'b1, RED | REQ, "store_redir"});

    // reset: outputs forced low even with active inputs
    rst_n = 1'b0;
    set_lu();
    EX_redirect = 1'b1;
    MEM_memread = 1'b1;
    #1;
    chk("rst_outs", a_out, NONE);
    tick();
    tick();
    idle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_scnt", a_scnt, 0);
    chk("rst_fcnt", a_fcnt, 0);
    chk("rst_err", {a_err, a_stk}, 0);
    chk("rst_idle", a_out, NONE);
    tick();

    e_stall = 0;
    e_flush = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk(tbl[i].nm, a_out, tbl[i].exp);
      if (tbl[i].exp[8]) e_stall++;
      if (tbl[i].exp[7]) e_flush++;
      tick();
    end
    chk("tbl_scnt", a_scnt, e_stall);
    chk("tbl_fcnt", a_fcnt, e_flush);

    // memory wait: ack three cycles after request
    do_reset();
    n_req = 0;
    n_ems = 0;
    for (int i = 0; i < 4; i++) begin
      idle();
      MEM_memread = 1'b1;
      dmem_ack = (i == 3);
      @(negedge clk);
      n_req += int'(a_req);
      n_ems += int'(a_ems);
      chk("mw_cycle", a_out, (i < 3) ? WAIT : REQ);
      tick();
    end
    idle();
    @(negedge clk);
    chk("mw_run", a_out, NONE);
    chk("mw_req_cycles", n_req, 4);
    chk("mw_ems_cycles", n_ems, 3);
    chk("mw_scnt", a_scnt, 3);
    tick();

    // redirect held in EX across a two-cycle wait
    f0 = int'(a_fcnt);
    for (int i = 0; i < 3; i++) begin
      idle();
      MEM_memread = 1'b1;
      EX_redirect = 1'b1;
      dmem_ack = (i == 2);
      @(negedge clk);
      chk("rw_cycle", a_out, (i < 2) ? WAIT : (RED | REQ));
      tick();
    end
    idle();
    chk("rw_fcnt", a_fcnt, f0 + 1);

    // watchdog on the TIMEOUT=4 instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      MEM_memread = 1'b1;
      @(negedge clk);
      chk("wd_cycle", b_out, (i < 3) ? WAIT : REQ);
      if (i == 3) chk("wd_err_lat", b_err, 0);
      tick();
    end
    idle();
    n_err = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      n_err += int'(b_err);
      if (j == 0) begin
        chk("wd_err", b_err, 1);
        chk("wd_run", b_out, NONE);
      end
      tick();
    end
    chk("wd_pulses", n_err, 1);
    chk("wd_sticky", b_stk, 1);
    rst_n = 1'b0;
    #1;
    chk("wd_sticky_rst", b_stk, 0);
    do_reset();

    // saturation on the CNT_W=2 instance
    for (int i = 0; i < 5; i++) begin
      set_lu();
      tick();
    end
    idle();
    chk("sat_b", b_scnt, 3);
    chk("sat_a", a_scnt, 5);

    // asynchronous reset in the middle of MWAIT
    do_reset();
    EX_redirect = 1'b1;
    tick();
    idle();
    MEM_memread = 1'b1;
    tick();
    tick();
    chk("ar_pre_scnt", a_scnt, 2);
    chk("ar_pre_wait", a_out, WAIT);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outs", a_out, NONE);
    chk("ar_scnt", a_scnt, 0);
    chk("ar_fcnt", a_fcnt, 0);
    chk("ar_err", {a_err, a_stk}, 0);
    idle();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_run", a_out, NONE);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
